// File: rtl/coprocessor0_regfile.sv
// CP0 register file and exception controller: Status/Cause/EPC/Count/Compare/BadVAddr,
// the Count/Compare timer, exception commit, ERET redirect and interrupt-pending generation.

package coprocessor0_regfile_pkg;

    typedef struct packed {
        logic        write_enabled;
        logic [4:0]  address_register;
        logic [2:0]  select;
        logic [31:0] write_data;
        logic        exception_valid;
        logic [4:0]  exception_code;
        logic [31:0] exception_address;
        logic        in_delay_slot;
        logic        eret_flush;
    } wb_to_cp0_data_t;

    typedef struct packed {
        logic [31:0] exception_pc;
    } cp0_to_if_data_t;

endpackage

module coprocessor0_regfile
    import coprocessor0_regfile_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR_BEV1 = 32'hBFC0_0380,
    parameter logic [31:0] EXC_VECTOR_BEV0 = 32'h8000_0180
) (
    input  logic            clock,
    input  logic            reset,
    input  wb_to_cp0_data_t wb_to_cp0,
    input  logic [31:0]     bad_vaddr,
    input  logic [5:0]      hardware_interrupt,
    output logic [31:0]     read_data,
    output cp0_to_if_data_t cp0_to_if,
    output logic            interrupt_pending
);

    localparam logic [4:0] REG_BADVADDR = 5'd8;
    localparam logic [4:0] REG_COUNT    = 5'd9;
    localparam logic [4:0] REG_COMPARE  = 5'd11;
    localparam logic [4:0] REG_STATUS   = 5'd12;
    localparam logic [4:0] REG_CAUSE    = 5'd13;
    localparam logic [4:0] REG_EPC      = 5'd14;

    // A faulting instruction in a delay slot restarts at its branch.
    function automatic logic [31:0] epc_target(input logic [31:0] pc, input logic in_slot);
        epc_target = in_slot ? (pc - 32'd4) : pc;
    endfunction

    function automatic logic is_address_error(input logic [4:0] code);
        is_address_error = (code == 5'd4) || (code == 5'd5);
    endfunction

    logic        bev_r;
    logic [7:0]  im_r;
    logic        exl_r;
    logic        ie_r;
    logic        bd_r;
    logic        ti_r;
    logic [7:0]  ip_r;
    logic [4:0]  exc_code_r;
    logic [31:0] epc_r;
    logic [31:0] count_r;
    logic [31:0] compare_r;
    logic [31:0] bad_vaddr_r;
    logic        tick_r;

    logic        exception_s;
    logic        eret_s;
    logic        mtc0_s;
    logic        wr_count_s;
    logic        wr_compare_s;
    logic        wr_status_s;
    logic        wr_cause_s;
    logic        wr_epc_s;
    logic [31:0] status_s;
    logic [31:0] cause_s;

    // Request decode: a higher-priority request suppresses lower ones completely.
    always_comb begin
        exception_s  = wb_to_cp0.exception_valid;
        eret_s       = wb_to_cp0.eret_flush & ~wb_to_cp0.exception_valid;
        mtc0_s       = wb_to_cp0.write_enabled & ~wb_to_cp0.exception_valid
                       & ~wb_to_cp0.eret_flush & (wb_to_cp0.select == 3'd0);
        wr_count_s   = 1'b0;
        wr_compare_s = 1'b0;
        wr_status_s  = 1'b0;
        wr_cause_s   = 1'b0;
        wr_epc_s     = 1'b0;
        if (mtc0_s) begin
            case (wb_to_cp0.address_register)
                REG_COUNT:   wr_count_s   = 1'b1;
                REG_COMPARE: wr_compare_s = 1'b1;
                REG_STATUS:  wr_status_s  = 1'b1;
                REG_CAUSE:   wr_cause_s   = 1'b1;
                REG_EPC:     wr_epc_s     = 1'b1;
                default:     wr_count_s   = 1'b0;
            endcase
        end else begin
            wr_count_s = 1'b0;
        end
    end

    // Architectural views of Status and Cause.
    always_comb begin
        status_s = {9'd0, bev_r, 6'd0, im_r, 6'd0, exl_r, ie_r};
        cause_s  = {bd_r, ti_r, 14'd0, ip_r, 1'b0, exc_code_r, 2'b00};
    end

    // MFC0 read port; reflects current state, same-cycle writes are not bypassed.
    always_comb begin
        read_data = 32'd0;
        if (wb_to_cp0.select == 3'd0) begin
            case (wb_to_cp0.address_register)
                REG_BADVADDR: read_data = bad_vaddr_r;
                REG_COUNT:    read_data = count_r;
                REG_COMPARE:  read_data = compare_r;
                REG_STATUS:   read_data = status_s;
                REG_CAUSE:    read_data = cause_s;
                REG_EPC:      read_data = epc_r;
                default:      read_data = 32'd0;
            endcase
        end else begin
            read_data = 32'd0;
        end
    end

    // Redirect target and interrupt request.
    always_comb begin
        cp0_to_if.exception_pc = epc_r;
        if (exception_s) begin
            cp0_to_if.exception_pc = bev_r ? EXC_VECTOR_BEV1 : EXC_VECTOR_BEV0;
        end else begin
            cp0_to_if.exception_pc = epc_r;
        end
        interrupt_pending = ie_r & ~exl_r & (|(ip_r & im_r));
    end

    // CP0 state update: reset, timer, exception commit, ERET and MTC0.
    always_ff @(posedge clock) begin
        if (reset) begin
            bev_r       <= 1'b1;
            im_r        <= 8'd0;
            exl_r       <= 1'b0;
            ie_r        <= 1'b0;
            bd_r        <= 1'b0;
            ti_r        <= 1'b0;
            ip_r        <= 8'd0;
            exc_code_r  <= 5'd0;
            epc_r       <= 32'd0;
            count_r     <= 32'd0;
            compare_r   <= 32'd0;
            bad_vaddr_r <= 32'd0;
            tick_r      <= 1'b0;
        end else begin
            tick_r     <= ~tick_r;
            ip_r[7:2]  <= {hardware_interrupt[5] | ti_r, hardware_interrupt[4:0]};

            if (wr_count_s) begin
                count_r <= wb_to_cp0.write_data;
            end else if (tick_r) begin
                count_r <= count_r + 32'd1;
            end else begin
                count_r <= count_r;
            end

            // A Compare write acknowledges the timer even on a match cycle.
            if (wr_compare_s) begin
                compare_r <= wb_to_cp0.write_data;
                ti_r      <= 1'b0;
            end else if (count_r == compare_r) begin
                ti_r <= 1'b1;
            end else begin
                ti_r <= ti_r;
            end

            if (exception_s) begin
                exl_r      <= 1'b1;
                exc_code_r <= wb_to_cp0.exception_code;
                if (!exl_r) begin
                    epc_r <= epc_target(wb_to_cp0.exception_address, wb_to_cp0.in_delay_slot);
                    bd_r  <= wb_to_cp0.in_delay_slot;
                end else begin
                    epc_r <= epc_r;
                end
                if (is_address_error(wb_to_cp0.exception_code)) begin
                    bad_vaddr_r <= bad_vaddr;
                end else begin
                    bad_vaddr_r <= bad_vaddr_r;
                end
            end else if (eret_s) begin
                exl_r <= 1'b0;
            end else begin
                if (wr_status_s) begin
                    im_r  <= wb_to_cp0.write_data[15:8];
                    exl_r <= wb_to_cp0.write_data[1];
                    ie_r  <= wb_to_cp0.write_data[0];
                end else begin
                    im_r <= im_r;
                end
                if (wr_cause_s) begin
                    ip_r[1:0] <= wb_to_cp0.write_data[9:8];
                end else begin
                    ip_r[1:0] <= ip_r[1:0];
                end
                if (wr_epc_s) begin
                    epc_r <= wb_to_cp0.write_data;
                end else begin
                    epc_r <= epc_r;
                end
            end
        end
    end

endmodule

// File: tb/tb_coprocessor0_regfile.sv
// Directed self-checking bench for coprocessor0_regfile with hand-computed expectations.

module tb_coprocessor0_regfile;
    import coprocessor0_regfile_pkg::*;

    logic            clock;
    logic            reset;
    wb_to_cp0_data_t wb_to_cp0;
    logic [31:0]     bad_vaddr;
    logic [5:0]      hardware_interrupt;
    logic [31:0]     read_data;
    cp0_to_if_data_t cp0_to_if;
    logic            interrupt_pending;

    int checks_r   = 0;
    int failures_r = 0;

    coprocessor0_regfile dut (
        .clock              (clock),
        .reset              (reset),
        .wb_to_cp0          (wb_to_cp0),
        .bad_vaddr          (bad_vaddr),
        .hardware_interrupt (hardware_interrupt),
        .read_data          (read_data),
        .cp0_to_if          (cp0_to_if),
        .interrupt_pending  (interrupt_pending)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_r = checks_r + 1;
        if (got !== exp) begin
            failures_r = failures_r + 1;
            $display("FAIL %s got=%08h expected=%08h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic idle_inputs();
        wb_to_cp0 = '0;
        bad_vaddr = 32'd0;
    endtask

    task automatic mtc0(input logic [4:0] addr, input logic [2:0] sel, input logic [31:0] data);
        wb_to_cp0.write_enabled    = 1'b1;
        wb_to_cp0.address_register = addr;
        wb_to_cp0.select           = sel;
        wb_to_cp0.write_data       = data;
        step(1);
        idle_inputs();
    endtask

    task automatic mfc0_check(input string tag, input logic [4:0] addr, input logic [2:0] sel,
                              input logic [31:0] exp);
        wb_to_cp0.address_register = addr;
        wb_to_cp0.select           = sel;
        #1;
        check_value(tag, read_data, exp);
        wb_to_cp0.address_register = 5'd0;
        wb_to_cp0.select           = 3'd0;
    endtask

    task automatic raise_exception(input logic [4:0] code, input logic slot, input logic [31:0] pc,
                                   input logic [31:0] bva, input logic [31:0] exp_vector,
                                   input string tag);
        wb_to_cp0.exception_valid   = 1'b1;
        wb_to_cp0.exception_code    = code;
        wb_to_cp0.in_delay_slot     = slot;
        wb_to_cp0.exception_address = pc;
        bad_vaddr                   = bva;
        #1;
        check_value(tag, cp0_to_if.exception_pc, exp_vector);
        step(1);
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        hardware_interrupt = 6'd0;
        reset = 1'b1;
        step(3);
        reset = 1'b0;

        // Reset state; the timer advances once every two edges from here.
        mfc0_check("rst_status", 5'd12, 3'd0, 32'h0040_0000);
        mfc0_check("rst_epc", 5'd14, 3'd0, 32'h0000_0000);
        mfc0_check("rst_count", 5'd9, 3'd0, 32'h0000_0000);
        check_value("rst_expc", cp0_to_if.exception_pc, 32'h0000_0000);
        check_value("rst_intp", {31'd0, interrupt_pending}, 32'd0);
        step(10);
        mfc0_check("count_10cyc", 5'd9, 3'd0, 32'd5);

        // Timer match: Count reaches 20 ten increments after the write.
        mtc0(5'd11, 3'd0, 32'd20);
        mtc0(5'd9, 3'd0, 32'd10);
        mtc0(5'd12, 3'd0, 32'h0000_8001);
        step(19);
        mfc0_check("count_at_cmp", 5'd9, 3'd0, 32'd20);
        mfc0_check("ti_before", 5'd13, 3'd0, 32'h0000_0000);
        step(1);
        mfc0_check("ti_set", 5'd13, 3'd0, 32'h4000_0000);
        check_value("intp_lag", {31'd0, interrupt_pending}, 32'd0);
        step(1);
        mfc0_check("ip7_set", 5'd13, 3'd0, 32'h4000_8000);
        check_value("intp_timer", {31'd0, interrupt_pending}, 32'd1);
        mtc0(5'd11, 3'd0, 32'h0000_1000);
        mfc0_check("ti_clear", 5'd13, 3'd0, 32'h0000_8000);
        step(1);
        check_value("intp_clear", {31'd0, interrupt_pending}, 32'd0);

        // External line and software interrupt bits.
        hardware_interrupt = 6'b000001;
        step(1);
        mfc0_check("hw_ip2", 5'd13, 3'd0, 32'h0000_0400);
        hardware_interrupt = 6'd0;
        mtc0(5'd13, 3'd0, 32'hFFFF_FFFF);
        mfc0_check("cause_wmask", 5'd13, 3'd0, 32'h0000_0300);
        check_value("intp_masked", {31'd0, interrupt_pending}, 32'd0);
        mtc0(5'd13, 3'd0, 32'h0000_0000);

        // Address error in a delay slot.
        raise_exception(5'd5, 1'b1, 32'hBFC0_1004, 32'h0000_0013, 32'hBFC0_0380, "exc1_vec");
        mfc0_check("exc1_epc", 5'd14, 3'd0, 32'hBFC0_1000);
        mfc0_check("exc1_cause", 5'd13, 3'd0, 32'h8000_0014);
        mfc0_check("exc1_bva", 5'd8, 3'd0, 32'h0000_0013);
        mfc0_check("exc1_status", 5'd12, 3'd0, 32'h0040_8003);

        // Nested exception keeps EPC/BD; ExcCode 8 leaves BadVAddr alone.
        raise_exception(5'd8, 1'b0, 32'h0000_0100, 32'h0000_0055, 32'hBFC0_0380, "exc2_vec");
        mfc0_check("exc2_epc", 5'd14, 3'd0, 32'hBFC0_1000);
        mfc0_check("exc2_cause", 5'd13, 3'd0, 32'h8000_0020);
        mfc0_check("exc2_bva", 5'd8, 3'd0, 32'h0000_0013);

        wb_to_cp0.eret_flush = 1'b1;
        #1;
        check_value("eret_pc", cp0_to_if.exception_pc, 32'hBFC0_1000);
        step(1);
        idle_inputs();
        mfc0_check("eret_status", 5'd12, 3'd0, 32'h0040_8001);

        // Exception + ERET + MTC0 together: only the exception acts.
        wb_to_cp0.eret_flush       = 1'b1;
        wb_to_cp0.write_enabled    = 1'b1;
        wb_to_cp0.address_register = 5'd12;
        wb_to_cp0.write_data       = 32'h0000_0000;
        raise_exception(5'd4, 1'b0, 32'h0000_0200, 32'h0000_0077, 32'hBFC0_0380, "prio_vec");
        mfc0_check("prio_status", 5'd12, 3'd0, 32'h0040_8003);
        mfc0_check("prio_epc", 5'd14, 3'd0, 32'h0000_0200);
        mfc0_check("prio_bva", 5'd8, 3'd0, 32'h0000_0077);
        mfc0_check("prio_cause", 5'd13, 3'd0, 32'h0000_0010);
        check_value("idle_expc", cp0_to_if.exception_pc, 32'h0000_0200);

        wb_to_cp0.eret_flush = 1'b1;
        step(1);
        idle_inputs();

        // Write masks and ignored targets.
        mtc0(5'd12, 3'd0, 32'hFFFF_FFFF);
        mfc0_check("status_mask", 5'd12, 3'd0, 32'h0040_FF03);
        mtc0(5'd8, 3'd0, 32'h0000_DEAD);
        mfc0_check("bva_ro", 5'd8, 3'd0, 32'h0000_0077);
        mtc0(5'd15, 3'd0, 32'h1234_5678);
        mfc0_check("reg15", 5'd15, 3'd0, 32'h0000_0000);
        mtc0(5'd12, 3'd1, 32'h0000_0000);
        mfc0_check("sel1_read", 5'd12, 3'd1, 32'h0000_0000);
        mfc0_check("sel1_nowr", 5'd12, 3'd0, 32'h0040_FF03);

        // Reset mid-operation with a pending write.
        wb_to_cp0.write_enabled    = 1'b1;
        wb_to_cp0.address_register = 5'd14;
        wb_to_cp0.write_data       = 32'hCAFE_0000;
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        idle_inputs();
        mfc0_check("rst2_status", 5'd12, 3'd0, 32'h0040_0000);
        mfc0_check("rst2_epc", 5'd14, 3'd0, 32'h0000_0000);
        check_value("rst2_intp", {31'd0, interrupt_pending}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks_r, failures_r);
        $finish;
    end

endmodule
